move_sequencer: RTL



---
 rtl/puzzle_pkg.sv | 26 ++
 rtl/board_swap.sv | 20 ++
 rtl/move_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared register indices, direction codes, geometry and FSM states for the move sequencer
package puzzle_pkg;
  localparam int NCELL = 7;
  localparam int CELL_W = 4;
  localparam int BOARD_W = NCELL * CELL_W;
  localparam logic [3:0] REG_BOARD = 4'd0;
  localparam logic [3:0] REG_IDEAL = 4'd1;
  localparam logic [3:0] REG_PLACE = 4'd2;
  localparam logic [3:0] REG_CNT = 4'd7;
  localparam logic [3:0] REG_IGNORE = 4'd15;
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_CHECK = 2'b10,
    DIR_RSVD  = 2'b11
  } dir_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_BOARD,
    S_WR_PLACE,
    S_WR_CNT,
    S_CHECK,
    S_RESP
  } state_t;
endpackage

// File: rtl/board_swap.sv
// board_swap: combinational exchange of two cells of a packed board
module board_swap
  import puzzle_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [2:0]         idx_a,
  input  logic [2:0]         idx_b,
  output logic [BOARD_W-1:0] swapped
);
  logic [CELL_W-1:0] cell_a, cell_b;
  assign cell_a = CELL_W'(board >> (CELL_W * idx_a));
  assign cell_b = CELL_W'(board >> (CELL_W * idx_b));
  always_comb begin
    swapped = board;
    for (int i = 0; i < NCELL; i++) begin
      if (idx_a == 3'(i)) swapped[i*CELL_W +: CELL_W] = cell_b;
      if (idx_b == 3'(i)) swapped[i*CELL_W +: CELL_W] = cell_a;
    end
  end
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: executes one puzzle move per command against a 16x28-bit register file
module move_sequencer
  import puzzle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_dir,
  output logic [3:0]         rf_src0,
  output logic [3:0]         rf_src1,
  input  logic [BOARD_W-1:0] rf_data0,
  input  logic [BOARD_W-1:0] rf_data1,
  input  logic [BOARD_W-1:0] rf_cnt,
  output logic [3:0]         rf_dst,
  output logic               rf_we,
  output logic [BOARD_W-1:0] rf_wdata,
  output logic               rsp_valid,
  output logic               rsp_ok,
  output logic               rsp_solved
);
  state_t state, next;
  dir_t dir_q;
  logic [BOARD_W-1:0] board_q, swapped;
  logic [2:0] place_q, place_in, target;
  logic ok_q, legal;
  assign place_in = rf_data1[2:0];
  assign legal = (dir_q == DIR_LEFT && place_in != 3'd0 && place_in != 3'd7) ||
                 (dir_q == DIR_RIGHT && place_in < 3'd6);
  assign target = dir_q == DIR_LEFT ? place_q - 3'd1 : place_q + 3'd1;
  board_swap u_swap (
    .board  (board_q),
    .idx_a  (place_q),
    .idx_b  (target),
    .swapped(swapped)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rsp_ok     <= 1'b0;
      rsp_solved <= 1'b0;
    end else begin
      state <= next;
      if (state == S_IDLE && cmd_valid) dir_q <= dir_t'(cmd_dir);
      if (state == S_READ) begin
        board_q <= rf_data0;
        place_q <= place_in;
        ok_q    <= legal || dir_q == DIR_CHECK;
      end
      // reserved commands answer straight from READ without a compare
      if (state == S_READ && dir_q == DIR_RSVD) begin
        rsp_ok     <= 1'b0;
        rsp_solved <= 1'b0;
      end
      if (state == S_CHECK) begin
        rsp_ok     <= ok_q;
        rsp_solved <= rf_data0 == rf_data1;
      end
    end
  end
  always_comb begin
    next      = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_src0   = REG_BOARD;
    rf_src1   = REG_IDEAL;
    rf_we     = 1'b0;
    rf_dst    = REG_IGNORE;
    rf_wdata  = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        next      = cmd_valid ? S_READ : S_IDLE;
      end
      S_READ: begin
        rf_src1 = REG_PLACE;
        next    = dir_q == DIR_RSVD ? S_RESP : legal ? S_WR_BOARD : S_CHECK;
      end
      S_WR_BOARD: begin
        rf_we    = 1'b1;
        rf_dst   = REG_BOARD;
        rf_wdata = swapped;
        next     = S_WR_PLACE;
      end
      S_WR_PLACE: begin
        rf_we    = 1'b1;
        rf_dst   = REG_PLACE;
        rf_wdata = BOARD_W'(target);
        next     = S_WR_CNT;
      end
      S_WR_CNT: begin
        rf_we    = 1'b1;
        rf_dst   = REG_CNT;
        rf_wdata = rf_cnt + BOARD_W'(1);
        next     = S_CHECK;
      end
      S_CHECK: next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        next      = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end
endmodule
